// File: rtl/hwpe_stream_burst_source_if.sv
// HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_burst_source.sv
// Programmable HWPE-Stream burst source: len_i beats of seed + k*stride (or Galois LFSR with HWPE_STREAM_BURST_SOURCE_LFSR_EN).
// Latency: first beat valid 1 cycle after start_i, then 1 beat/cycle under sustained tx.ready.
// Backpressure: valid and data hold stable while tx.ready=0; tx.ready never reaches tx.valid combinationally.
module hwpe_stream_burst_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic [DATA_WIDTH-1:0]  seed_i,
  input  logic [DATA_WIDTH-1:0]  stride_i,
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
  input  logic                   lfsr_mode_i,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LEN_WIDTH-1:0]   count_o,
  hwpe_stream_intf_stream.source tx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] stride;
  } burst_cfg_t;

  state_e                 state_q;
  burst_cfg_t             cfg_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic [DATA_WIDTH-1:0]  seed_eff;
  logic [LEN_WIDTH-1:0]   count_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   hs;
  logic                   last_beat;

  assign hs        = valid_q & tx.ready;
  assign last_beat = (count_q == cfg_q.len - LEN_WIDTH'(1));

`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] LFSR_POLY = DATA_WIDTH'(32'h8020_0003);

  logic lfsr_q;

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  always_comb begin
    seed_eff = seed_i;
    if (lfsr_mode_i && (seed_i == '0)) seed_eff = DATA_WIDTH'(1);
    data_nxt = data_q + cfg_q.stride;
    if (lfsr_q) begin
      data_nxt = {data_q[DATA_WIDTH-2:0], 1'b0} ^ (data_q[DATA_WIDTH-1] ? LFSR_POLY : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 1'b0;
    end else if (clear_i) begin
      lfsr_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      lfsr_q <= lfsr_mode_i;
    end
  end
`else
  assign seed_eff = seed_i;
  assign data_nxt = data_q + cfg_q.stride;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_q.len    <= len_i;
            cfg_q.stride <= stride_i;
            data_q       <= seed_eff;
            count_q      <= '0;
            if (len_i != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            data_q  <= data_nxt;
            count_q <= count_q + LEN_WIDTH'(1);
            if (last_beat) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx.valid = valid_q;
  assign tx.data  = data_q;
  assign tx.strb  = '1;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign count_o  = count_q;

endmodule

// File: tb/tb_hwpe_stream_burst_source.sv
// Bench for hwpe_stream_burst_source: directed vector table, hand sequences for clear/reset, randomized bursts vs closed-form model.
module tb_hwpe_stream_burst_source;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [15:0] len_in;
  logic [31:0] seed_in;
  logic [31:0] stride_in;
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
  logic        lfsr_mode;
`endif
  logic        busy;
  logic        done;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) tx_if ();

  hwpe_stream_burst_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .start_i    (start),
    .len_i      (len_in),
    .seed_i     (seed_in),
    .stride_i   (stride_in),
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
    .lfsr_mode_i(lfsr_mode),
`endif
    .busy_o     (busy),
    .done_o     (done),
    .count_o    (count),
    .tx         (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Beat k of a burst: arithmetic closed form, or k multiplications by x modulo x^32+0x80200003.
  function automatic logic [31:0] model_beat(input logic [31:0] seed, input logic [31:0] stride,
                                             input int k, input bit lfsr);
    logic [32:0] v;
    if (!lfsr) return seed + stride * 32'(k);
    v = {1'b0, (seed == 32'd0) ? 32'd1 : seed};
    for (int i = 0; i < k; i++) begin
      v = v << 1;
      if (v[32]) v = v ^ 33'h1_8020_0003;
    end
    return v[31:0];
  endfunction

  task automatic run_burst(input string tag, input int len, input logic [31:0] seed,
                           input logic [31:0] stride, input bit lfsr, input bit rnd,
                           input logic [31:0] pat, input int repulse,
                           output int n_acc, output logic [31:0] last, output int done_cyc);
    int budget;
    n_acc    = 0;
    last     = 32'd0;
    done_cyc = 0;
    budget   = 30 * len + 10;
    len_in    = 16'(len);
    seed_in   = seed;
    stride_in = stride;
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
    lfsr_mode = lfsr;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    len_in    = 16'($urandom);
    seed_in   = $urandom;
    stride_in = $urandom;
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
    lfsr_mode = 1'($urandom_range(0, 1));
`endif
    for (int cyc = 1; cyc <= budget; cyc++) begin
      start = (cyc == repulse);
      if (done) begin
        done_cyc = cyc;
        chk({tag, " done_count"}, count, 64'(len));
        chk({tag, " done_valid"}, tx_if.valid, 0);
        chk({tag, " done_busy"}, busy, 0);
        break;
      end
      chk({tag, " valid"}, tx_if.valid, 64'(n_acc < len));
      if (tx_if.valid) begin
        chk({tag, " data"}, tx_if.data, model_beat(seed, stride, n_acc, lfsr));
        chk({tag, " busy"}, busy, 1);
        chk({tag, " count"}, count, 64'(n_acc));
      end
      tx_if.ready = rnd ? ($urandom_range(0, 3) != 0) : pat[(cyc - 1) % 32];
      if (tx_if.valid && tx_if.ready) begin
        last = tx_if.data;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc == 0) chk({tag, " timeout_done"}, done, 1);
    @(posedge clk); #1;
    chk({tag, " post_done"}, done, 0);
    chk({tag, " post_valid"}, tx_if.valid, 0);
    chk({tag, " post_busy"}, busy, 0);
    chk({tag, " post_count_hold"}, count, 64'(len));
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [31:0] seed;
    logic [31:0] stride;
    bit          lfsr;
    logic [31:0] pat;
    int          repulse;
    logic [31:0] exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          n_acc;
    int          dcyc;
    logic [31:0] last;

    vecs.push_back('{"basic",       4, 32'h10,       32'h4,        1'b0, 32'hFFFF_FFFF, 0, 32'h1C,       5});
    vecs.push_back('{"backpress",   3, 32'hA,        32'h1,        1'b0, 32'h0000_0034, 0, 32'hC,        7});
    vecs.push_back('{"wrap",        2, 32'hFFFF_FFFF, 32'h2,       1'b0, 32'hFFFF_FFFF, 0, 32'h1,        3});
    vecs.push_back('{"len0",        0, 32'h5,        32'h1,        1'b0, 32'hFFFF_FFFF, 0, 32'h0,        1});
    vecs.push_back('{"len1",        1, 32'h55,       32'h100,      1'b0, 32'hFFFF_FFFF, 0, 32'h55,       2});
    vecs.push_back('{"msb",         3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 0, 32'h8000_0000, 4});
    vecs.push_back('{"repulse_run", 8, 32'h0,        32'h1,        1'b0, 32'hFFFF_FFFF, 3, 32'h7,        9});
    vecs.push_back('{"repulse_done",8, 32'h40,       32'h2,        1'b0, 32'hFFFF_FFFF, 9, 32'h4E,       9});
    vecs.push_back('{"alt_ready",   4, 32'h1000,     32'h10,       1'b0, 32'hAAAA_AAAA, 0, 32'h1030,     9});
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
    vecs.push_back('{"lfsr_seed0",  3, 32'h0,        32'h5,        1'b1, 32'hFFFF_FFFF, 0, 32'h4,        4});
    vecs.push_back('{"lfsr_msb",    2, 32'h8000_0000, 32'h7,       1'b1, 32'hFFFF_FFFF, 0, 32'h8020_0003, 3});
`endif

    rst_n       = 1'b0;
    clear       = 1'b0;
    start       = 1'b0;
    len_in      = 16'd0;
    seed_in     = 32'd0;
    stride_in   = 32'd0;
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
    lfsr_mode   = 1'b0;
`endif
    tx_if.ready = 1'b1;
    #3;
    chk("rst_valid", tx_if.valid, 0);
    chk("rst_data", tx_if.data, 0);
    chk("rst_strb", tx_if.strb, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_burst(vecs[i].name, vecs[i].len, vecs[i].seed, vecs[i].stride, vecs[i].lfsr, 1'b0,
                vecs[i].pat, vecs[i].repulse, n_acc, last, dcyc);
      chk({vecs[i].name, " last_beat"}, last, vecs[i].exp_last);
      chk({vecs[i].name, " done_cycle"}, 64'(dcyc), 64'(vecs[i].exp_done));
      chk({vecs[i].name, " beats"}, 64'(n_acc), 64'(vecs[i].len));
    end

    // Clear after three accepted beats aborts without a done pulse.
    len_in = 16'd8; seed_in = 32'h100; stride_in = 32'h1; tx_if.ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_pre_count", count, 3);
    chk("clr_pre_data", tx_if.data, 32'h103);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_valid", tx_if.valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_count", count, 0);
    chk("clr_done", done, 0);
    chk("clr_data", tx_if.data, 0);
    @(posedge clk); #1;
    chk("clr_no_done", done, 0);
    chk("clr_idle_valid", tx_if.valid, 0);

    // Asynchronous reset between clock edges mid-burst.
    len_in = 16'd8; seed_in = 32'h200; stride_in = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("arst_pre_valid", tx_if.valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_if.valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_data", tx_if.data, 0);
    chk("arst_done", done, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle_valid", tx_if.valid, 0);

    for (int r = 0; r < 30; r++) begin
      int          rl;
      logic [31:0] rs;
      logic [31:0] rst_v;
      bit          rlf;
      rl    = $urandom_range(0, 20);
      rs    = $urandom;
      rst_v = $urandom;
      rlf   = 1'b0;
`ifdef HWPE_STREAM_BURST_SOURCE_LFSR_EN
      rlf   = 1'($urandom_range(0, 1));
`endif
      run_burst("rand", rl, rs, rst_v, rlf, 1'b1, 32'h0, 0, n_acc, last, dcyc);
      chk("rand beats", 64'(n_acc), 64'(rl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
